// File: rtl/fp_align_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_align_pkg
// Brief   : Shared types and width helpers for the FPU add/sub align stage.
// Revision: 1.0 - initial release
// ============================================================================
package fp_align_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int DEF_TAG_W = 3;

  typedef struct packed {
    logic zero;
    logic sub;
    logic inf;
    logic qnan;
    logic snan;
  } fp_class_t;

  // Flag payload carried from S1 to S2 and presented unchanged at the output.
  typedef struct packed {
    logic res_sign;
    logic eff_sub;
    logic is_nan;
    logic invalid;
    logic is_inf;
    logic exact_cancel;
  } align_flags_t;

  // Aligned width: carry, hidden, fraction, guard, round.
  function automatic int aln_w(input int man_w);
    return man_w + 4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_align_if.sv
`default_nettype none
// ============================================================================
// Module  : fp_align_if
// Brief   : Input/output handshake and data bundle of the align stage.
// Revision: 1.0 - initial release
// ============================================================================
interface fp_align_if
  import fp_align_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int TAG_W = DEF_TAG_W
);
  localparam int ALN_W = aln_w(MAN_W);
  localparam int OP_W  = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic             add_sub;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic             res_sign;
  logic             eff_sub;
  logic [EXP_W-1:0] exp_res;
  logic [ALN_W-1:0] man_big;
  logic [ALN_W-1:0] man_small;
  logic             sticky;
  logic             is_nan;
  logic             invalid;
  logic             is_inf;
  logic             exact_cancel;

  modport master (
    output in_valid, add_sub, op_a, op_b, in_tag, out_ready,
    input  in_ready, out_valid, out_tag, res_sign, eff_sub, exp_res,
           man_big, man_small, sticky, is_nan, invalid, is_inf, exact_cancel
  );

  modport slave (
    input  in_valid, add_sub, op_a, op_b, in_tag, out_ready,
    output in_ready, out_valid, out_tag, res_sign, eff_sub, exp_res,
           man_big, man_small, sticky, is_nan, invalid, is_inf, exact_cancel
  );
endinterface
`default_nettype wire

// File: rtl/fp_rshift_sticky.sv
`default_nettype none
// ============================================================================
// Module  : fp_rshift_sticky
// Brief   : Saturating barrel right-shift; sticky OR when FP_ALIGN_STICKY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module fp_rshift_sticky #(
  parameter int W    = 27,
  parameter int SH_W = 8
) (
  input  logic [W-1:0]    i_din,
  input  logic [SH_W-1:0] i_shamt,
  output logic [W-1:0]    o_dout,
  output logic            o_sticky
);

  logic w_sat;

  assign w_sat  = (32'(i_shamt) >= 32'(W));
  assign o_dout = w_sat ? '0 : (i_din >> i_shamt);

`ifdef FP_ALIGN_STICKY_EN
  logic [W-1:0] w_mask;

  // Low i_shamt bits set: exactly the positions that fall off the bottom.
  assign w_mask   = ~({W{1'b1}} << i_shamt);
  assign o_sticky = w_sat ? (|i_din) : (|(i_din & w_mask));
`else
  assign o_sticky = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/fp_align_stage.sv
`default_nettype none
// ============================================================================
// Module  : fp_align_stage
// Brief   : Two-stage unpack/swap/align for the FPU add/sub path.
// Revision: 1.0 - initial release
// ============================================================================
module fp_align_stage
  import fp_align_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     flush,
  fp_align_if.slave bus
);

  localparam int ALN_W = aln_w(MAN_W);
  localparam logic [EXP_W-1:0] c_exp_one = EXP_W'(1);

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    fp_class_t c;
    c.zero = (e == '0) && (f == '0);
    c.sub  = (e == '0) && (f != '0);
    c.inf  = (&e) && (f == '0);
    c.qnan = (&e) && f[MAN_W-1];
    c.snan = (&e) && !f[MAN_W-1] && (f != '0);
    return c;
  endfunction

  logic             w_sa, w_sb, w_sb_eff;
  logic [EXP_W-1:0] w_ea, w_eb, w_eea, w_eeb, w_big_exp, w_diff;
  logic [MAN_W-1:0] w_fa, w_fb;
  fp_class_t        w_ca, w_cb;
  logic [ALN_W-1:0] w_siga, w_sigb, w_big_sig, w_small_sig, w_sh_man;
  logic             w_a_big, w_mag_eq, w_eff_sub, w_any_nan, w_any_inf, w_invalid, w_cancel;
  logic             w_sh_sticky, w_s1_adv, w_s2_adv;
  align_flags_t     w_flags;

  logic             r_s1_valid, r_s2_valid;
  align_flags_t     r_s1_flags, r_s2_flags;
  logic [ALN_W-1:0] r_s1_big, r_s1_small, r_s2_big, r_s2_small;
  logic [EXP_W-1:0] r_s1_exp, r_s1_diff, r_s2_exp;
  logic [TAG_W-1:0] r_s1_tag, r_s2_tag;
  logic             r_s2_sticky;

  assign {w_sa, w_ea, w_fa} = bus.op_a;
  assign {w_sb, w_eb, w_fb} = bus.op_b;
  assign w_ca = classify(w_ea, w_fa);
  assign w_cb = classify(w_eb, w_fb);

  // Subnormals and zeros share the minimum normal exponent with no hidden bit.
  assign w_eea  = (w_ca.zero | w_ca.sub) ? c_exp_one : w_ea;
  assign w_eeb  = (w_cb.zero | w_cb.sub) ? c_exp_one : w_eb;
  assign w_siga = {1'b0, ~(w_ca.zero | w_ca.sub), w_fa, 2'b00};
  assign w_sigb = {1'b0, ~(w_cb.zero | w_cb.sub), w_fb, 2'b00};

  assign w_sb_eff  = w_sb ^ bus.add_sub;
  assign w_eff_sub = w_sa ^ w_sb_eff;
  assign w_a_big   = {w_ea, w_fa} >= {w_eb, w_fb};
  assign w_mag_eq  = {w_ea, w_fa} == {w_eb, w_fb};
  assign w_any_nan = w_ca.qnan | w_ca.snan | w_cb.qnan | w_cb.snan;
  assign w_any_inf = w_ca.inf | w_cb.inf;
  assign w_invalid = w_ca.snan | w_cb.snan | (w_ca.inf & w_cb.inf & w_eff_sub);
  assign w_cancel  = w_eff_sub & w_mag_eq & ~w_any_nan & ~w_any_inf;

  always_comb begin
    w_flags              = '0;
    w_flags.res_sign     = w_a_big ? w_sa : w_sb_eff;
    w_flags.eff_sub      = w_eff_sub;
    w_flags.is_nan       = w_any_nan | w_invalid;
    w_flags.invalid      = w_invalid;
    w_flags.is_inf       = w_any_inf & ~(w_any_nan | w_invalid);
    w_flags.exact_cancel = w_cancel;
  end

  // Exact cancellation forces a clean zero payload through the shifter.
  assign w_big_sig   = w_cancel ? '0 : (w_a_big ? w_siga : w_sigb);
  assign w_small_sig = w_cancel ? '0 : (w_a_big ? w_sigb : w_siga);
  assign w_big_exp   = w_cancel ? '0 : (w_a_big ? w_eea : w_eeb);
  assign w_diff      = w_a_big ? (w_eea - w_eeb) : (w_eeb - w_eea);

  assign w_s2_adv     = ~r_s2_valid | bus.out_ready;
  assign w_s1_adv     = w_s2_adv | ~r_s1_valid;
  assign bus.in_ready = w_s1_adv;

  fp_rshift_sticky #(
    .W    (ALN_W),
    .SH_W (EXP_W)
  ) u_rshift (
    .i_din    (r_s1_small),
    .i_shamt  (r_s1_diff),
    .o_dout   (w_sh_man),
    .o_sticky (w_sh_sticky)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_flags  <= '0;
      r_s1_big    <= '0;
      r_s1_small  <= '0;
      r_s1_exp    <= '0;
      r_s1_diff   <= '0;
      r_s1_tag    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_flags  <= '0;
      r_s2_big    <= '0;
      r_s2_small  <= '0;
      r_s2_exp    <= '0;
      r_s2_tag    <= '0;
      r_s2_sticky <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_flags <= w_flags;
          r_s1_big   <= w_big_sig;
          r_s1_small <= w_small_sig;
          r_s1_exp   <= w_big_exp;
          r_s1_diff  <= w_diff;
          r_s1_tag   <= bus.in_tag;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_flags  <= r_s1_flags;
          r_s2_big    <= r_s1_big;
          r_s2_small  <= w_sh_man;
          r_s2_exp    <= r_s1_exp;
          r_s2_tag    <= r_s1_tag;
          r_s2_sticky <= w_sh_sticky;
        end
      end
    end
  end

  assign bus.out_valid    = r_s2_valid;
  assign bus.out_tag      = r_s2_tag;
  assign bus.res_sign     = r_s2_flags.res_sign;
  assign bus.eff_sub      = r_s2_flags.eff_sub;
  assign bus.exp_res      = r_s2_exp;
  assign bus.man_big      = r_s2_big;
  assign bus.man_small    = r_s2_small;
  assign bus.sticky       = r_s2_sticky;
  assign bus.is_nan       = r_s2_flags.is_nan;
  assign bus.invalid      = r_s2_flags.invalid;
  assign bus.is_inf       = r_s2_flags.is_inf;
  assign bus.exact_cancel = r_s2_flags.exact_cancel;

endmodule
`default_nettype wire

// File: tb/tb_fp_align_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_align_stage
// Brief   : Directed self-checking bench for fp_align_stage (single precision).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp_align_stage;

`ifdef FP_ALIGN_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic flush;
  int   n_assert = 0;
  int   n_fail   = 0;

  fp_align_if #(.EXP_W(8), .MAN_W(23), .TAG_W(3)) bus ();

  fp_align_stage #(.EXP_W(8), .MAN_W(23), .TAG_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string t, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [2:0] tg);
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.add_sub  = s;
    bus.in_tag   = tg;
  endtask

  // One transaction with out_ready=1; checks latency and every output field.
  task automatic run_vec(input string t, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [2:0] tg, input logic [7:0] e_exp,
                         input logic [26:0] e_mb, input logic [26:0] e_ms, input logic e_st,
                         input logic e_es, input logic e_rs, input logic [3:0] e_fl);
    int n;
    drive(a, b, s, tg);
    check({t, "_rdy"}, 32'(bus.in_ready), 32'(1));
    step();
    bus.in_valid = 1'b0;
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 6) begin
      @(negedge clk);
      n++;
    end
    check({t, "_lat"}, n, 32'(2));
    check({t, "_tag"}, 32'(bus.out_tag), 32'(tg));
    check({t, "_exp"}, 32'(bus.exp_res), 32'(e_exp));
    check({t, "_mbig"}, 32'(bus.man_big), 32'(e_mb));
    check({t, "_msmall"}, 32'(bus.man_small), 32'(e_ms));
    check({t, "_sticky"}, 32'(bus.sticky), 32'(e_st));
    check({t, "_effsub"}, 32'(bus.eff_sub), 32'(e_es));
    check({t, "_sign"}, 32'(bus.res_sign), 32'(e_rs));
    check({t, "_flags"}, 32'({bus.is_nan, bus.invalid, bus.is_inf, bus.exact_cancel}), 32'(e_fl));
  endtask

  initial begin
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.add_sub   = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_oval", 32'(bus.out_valid), 32'(0));
    check("rst_irdy", 32'(bus.in_ready), 32'(1));
    check("rst_data", 32'(bus.man_big | bus.man_small), 32'(0));
    check("rst_exp_tag", 32'({bus.exp_res, bus.out_tag}), 32'(0));
    check("rst_flags", 32'({bus.sticky, bus.is_nan, bus.invalid, bus.is_inf, bus.exact_cancel}), 32'(0));
    reset_n = 1'b1;
    step();
    check("post_rst_irdy", 32'(bus.in_ready), 32'(1));

    // Directed vectors: name, a, b, sub, tag, exp, man_big, man_small, sticky, eff_sub, sign, {nan,inv,inf,canc}
    run_vec("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 3'd1, 8'h7F, 27'h2000000, 27'h2000000, 1'b0, 1'b0, 1'b0, 4'b0000);
    run_vec("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 8'h00, 27'h0, 27'h0, 1'b0, 1'b1, 1'b0, 4'b0001);
    run_vec("far_small", 32'h3F800000, 32'h30800000, 1'b0, 3'd3, 8'h7F, 27'h2000000, 27'h0, STK, 1'b0, 1'b0, 4'b0000);
    run_vec("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 3'd4, 8'hFF, 27'h2000000, 27'h2000000, 1'b0, 1'b1, 1'b0, 4'b1100);
    run_vec("subnormal", 32'h00000001, 32'h00800000, 1'b0, 3'd5, 8'h01, 27'h2000000, 27'h0000004, 1'b0, 1'b0, 1'b0, 4'b0000);
    run_vec("shift3_sticky", 32'h41000000, 32'h3F800001, 1'b0, 3'd6, 8'h82, 27'h2000000, 27'h0400000, STK, 1'b0, 1'b0, 4'b0000);
    run_vec("swap_neg", 32'h3F800000, 32'hC0000000, 1'b0, 3'd7, 8'h80, 27'h2000000, 27'h1000000, 1'b0, 1'b1, 1'b1, 4'b0000);
    run_vec("qnan", 32'h7FC00000, 32'h3F800000, 1'b0, 3'd0, 8'hFF, 27'h3000000, 27'h0, STK, 1'b0, 1'b0, 4'b1000);
    run_vec("snan", 32'h7F800001, 32'h3F800000, 1'b0, 3'd5, 8'hFF, 27'h2000004, 27'h0, STK, 1'b0, 1'b0, 4'b1100);
    run_vec("neg_inf", 32'hFF800000, 32'h3F800000, 1'b0, 3'd6, 8'hFF, 27'h2000000, 27'h0, STK, 1'b1, 1'b1, 4'b0010);
    step();
    check("drain_oval", 32'(bus.out_valid), 32'(0));

    // Backpressure: two accepted, third refused, then ordered drain.
    bus.out_ready = 1'b0;
    drive(32'h3F800000, 32'h3F800000, 1'b0, 3'd1);
    check("bp_rdy1", 32'(bus.in_ready), 32'(1));
    step();
    drive(32'h41000000, 32'h3F800001, 1'b0, 3'd2);
    check("bp_rdy2", 32'(bus.in_ready), 32'(1));
    step();
    drive(32'h3F800000, 32'hC0000000, 1'b0, 3'd3);
    check("bp_rdy3", 32'(bus.in_ready), 32'(0));
    check("bp_tag_first", 32'(bus.out_tag), 32'(1));
    step();
    bus.in_valid = 1'b0;
    check("bp_hold_valid", 32'(bus.out_valid), 32'(1));
    check("bp_hold_data", 32'({bus.out_tag, bus.exp_res}), 32'({3'd1, 8'h7F}));
    bus.out_ready = 1'b1;
    step();
    check("bp_second", 32'({bus.out_valid, bus.out_tag, bus.exp_res}), 32'({1'b1, 3'd2, 8'h82}));
    check("bp_second_man", 32'(bus.man_small), 32'(27'h0400000));
    step();
    check("bp_no_third", 32'(bus.out_valid), 32'(0));

    // Flush with a simultaneous input: both the in-flight and the new one vanish.
    bus.out_ready = 1'b0;
    drive(32'h3F800000, 32'h3F800000, 1'b0, 3'd4);
    step();
    drive(32'h41000000, 32'h3F800001, 1'b0, 3'd5);
    flush = 1'b1;
    check("fl_rdy", 32'(bus.in_ready), 32'(1));
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_oval", 32'(bus.out_valid), 32'(0));
    bus.out_ready = 1'b1;
    step();
    check("fl_empty1", 32'(bus.out_valid), 32'(0));
    step();
    check("fl_empty2", 32'(bus.out_valid), 32'(0));

    // Asynchronous reset with two transactions in flight.
    bus.out_ready = 1'b0;
    drive(32'h3F800000, 32'h3F800000, 1'b0, 3'd6);
    step();
    drive(32'h41000000, 32'h3F800001, 1'b0, 3'd7);
    step();
    bus.in_valid = 1'b0;
    check("rs_full", 32'(bus.out_valid), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    check("rs_async_oval", 32'(bus.out_valid), 32'(0));
    check("rs_async_irdy", 32'(bus.in_ready), 32'(1));
    @(negedge clk);
    check("rs_cleared", 32'({bus.out_tag, bus.exp_res}), 32'(0));
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rs_nothing_left", 32'(bus.out_valid), 32'(0));
    run_vec("after_reset", 32'h3F800000, 32'hC0000000, 1'b1, 3'd2, 8'h80, 27'h2000000, 27'h1000000, 1'b0, 1'b0, 1'b0, 4'b0000);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_align_stage.md
# fp_align_stage

Parametrised, pipelined operand unpack-and-align stage for the FPU add/sub path. It accepts two packed IEEE-754 operands and an add/sub select, classifies them, and swaps them so the larger magnitude is first. It right-shifts the smaller significand with guard/round/sticky capture, then hands aligned significands and flags to the adder/normaliser stage over a valid/ready handshake. It replaces the single-precision combinational extract/align logic with a generic-width, two-stage, backpressure-aware block.

## Interface
- `EXP_W`, 8, exponent width.
- `MAN_W`, 23, stored fraction width; `ALN_W = MAN_W+4` (carry, hidden, fraction, guard, round).
- `TAG_W`, 3, opaque sideband (rounding mode/rd tag) carried alongside data.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: synchronous pipeline kill.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `add_sub` in 1: 0 = add, 1 = subtract (inverts operand-B sign).
- `op_a`, `op_b` in `1+EXP_W+MAN_W`: packed operands.
- `in_tag` in `TAG_W`, `out_tag` out `TAG_W`: sideband.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `res_sign` out 1: sign of the larger-magnitude operand.
- `eff_sub` out 1: effective signs differ.
- `exp_res` out `EXP_W`: effective exponent of the larger operand.
- `man_big`, `man_small` out `ALN_W`: aligned significands.
- `sticky` out 1: OR of bits shifted below round.
- `is_nan`, `invalid`, `is_inf`, `exact_cancel` out 1: special-case flags.

## Operation
- Unpack: `exp==0` is a subnormal or zero. Hidden bit = 0 and effective exponent = 1. Otherwise hidden = 1 and effective exponent = `exp`.
- Significand placement: `{1'b0, hidden, frac, 2'b00}`.
- Stage 1 (S1), registered:
  - classify each operand as zero, subnormal, inf or NaN;
  - effective sign B = `op_b` sign XOR `add_sub`;
  - compare magnitudes `{exp,frac}` and swap so that big ≥ small;
  - `diff = eff_exp_big - eff_exp_small`, unsigned, `EXP_W` bits.
- Stage 2 (S2), registered: `man_small = small >> diff`.
  - If `diff >= ALN_W`, `man_small = 0`.
  - `sticky` = OR of all bits shifted out below bit 0, or OR of the whole small significand when saturated.
- Flags:
  - `is_nan` = either operand NaN, or `invalid`.
  - `invalid` = either operand sNaN, or both inf with `eff_sub=1`.
  - `is_inf` = any inf and not `is_nan`.
  - `exact_cancel` = `eff_sub` and equal magnitudes and neither operand NaN/inf. When set, `man_big = man_small = 0`, `sticky = 0`, and `exp_res = 0`.
- `res_sign` on a tie takes operand A's sign. The downstream stage resolves the sign of a zero result from the rounding mode.

## Timing
- Latency is 2 cycles from input acceptance to `out_valid`. Throughput is 1 per cycle when `out_ready=1`.
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- S2 advances when S2 is empty or its output is taken. S1 advances when S2 can advance or S1 is empty. `in_ready` = S1 empty or S1 advancing, combinational from `out_ready`, with no skid buffer.
- With `out_ready=0`, the pipeline holds at most 2 transactions. Data and flags stay stable while `out_valid=1` and the output is not taken.
- `flush` clears both stage valids on the next edge. Input presented in the same cycle as `flush` is dropped. `flush` has priority over transfers.
- Reset: `out_valid=0`, all stage valids 0, and all data, flag and tag registers 0. `in_ready` is 1 after reset. Reset mid-operation discards in-flight transactions.

## Configuration
- `FP_ALIGN_STICKY_EN` defined: guard, round and sticky are captured as described above.
- Not defined: shifted-out bits below round are truncated and `sticky` is tied to 0. Guard and round bits are still shifted in, and the datapath is otherwise identical.

## Structure
- Package `fp_align_pkg` holds:
  - the `fp_class_t` struct (zero, sub, inf, qnan, snan);
  - the S1-to-S2 payload struct;
  - the `ALN_W` derivation function.
- Sub-module `fp_rshift_sticky` is a parametrised barrel right-shift with saturation and sticky OR. It is instantiated once in S2.

## Test plan
- 1.0+1.0 (`3F800000`, `3F800000`, add) → `exp_res=7F`, `man_big=man_small=0x2000000`, `eff_sub=0`, `sticky=0`.
- 1.0−1.0 → `exact_cancel=1`, mantissas 0, `exp_res=0`.
- 1.0 + 2^-30 (`3F800000`, `30800000`):
  - `diff=30 ≥ 27` → `man_small=0`;
  - `sticky=1` with the macro, 0 without.
- +inf − +inf (`7F800000`, `7F800000`, sub) → `invalid=1`, `is_nan=1`, `is_inf=0`.
- Subnormal `00000001` + `00800000` → both effective exponents are 1, `diff=0`, `man_small=0x0000004`.
- Backpressure: 3 back-to-back inputs with `out_ready=0` → 2 accepted, `in_ready=0` on the third.
  - Then `out_ready=1` → results emerge in order with no loss.
  - `flush` or `reset_n` mid-stream → `out_valid=0` the next cycle.
